// File: rtl/control_sequencer.sv
// Control sequencer: decodes 19-bit instructions into datapath strobes and
// owns the carry/zero flags, call-stack occupancy and run/halt/fault state.
module control_sequencer #(
  parameter int STACK_DEPTH = 8,
  parameter int LVL_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [18:0]      instruction,
  input  logic             alu_co,
  input  logic             alu_z,
  input  logic             shift_c,
  input  logic             shift_z,
  output logic             reg_write,
  output logic             mem_write,
  output logic             push,
  output logic             pop,
  output logic [2:0]       alu_op,
  output logic             alu_cin,
  output logic [1:0]       pc_sel,
  output logic             pc_en,
  output logic             flag_c,
  output logic             flag_z,
  output logic [LVL_W-1:0] stack_level,
  output logic             halted,
  output logic             fault
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_HALT  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(STACK_DEPTH);

  state_t           state_r;
  state_t           state_nx_s;
  logic             flag_c_r;
  logic             flag_z_r;
  logic             flag_c_nx_s;
  logic             flag_z_nx_s;
  logic [LVL_W-1:0] level_r;
  logic [LVL_W-1:0] level_nx_s;
  logic [1:0]       cls_s;
  logic [2:0]       sub_s;
  logic             unused_bits_s;

  assign cls_s         = instruction[18:17];
  assign sub_s         = instruction[16:14];
  assign unused_bits_s = ^instruction[13:0];

  assign flag_c      = flag_c_r;
  assign flag_z      = flag_z_r;
  assign stack_level = level_r;
  assign halted      = (state_r == ST_HALT);
  assign fault       = (state_r == ST_FAULT);

  // Instruction decode and next-state computation; only RUN produces strobes.
  always_comb begin
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    alu_op      = 3'b000;
    alu_cin     = 1'b0;
    pc_sel      = 2'b00;
    pc_en       = 1'b0;
    flag_c_nx_s = flag_c_r;
    flag_z_nx_s = flag_z_r;
    level_nx_s  = level_r;
    state_nx_s  = state_r;
    case (state_r)
      ST_INIT: begin
        state_nx_s = ST_RUN;
      end
      ST_RUN: begin
        pc_en = 1'b1;
        case (cls_s)
          2'b00, 2'b01: begin
            alu_op      = sub_s;
            reg_write   = 1'b1;
            flag_c_nx_s = alu_co;
            flag_z_nx_s = alu_z;
            if ((sub_s == 3'b001) || (sub_s == 3'b011)) begin
              alu_cin = flag_c_r;
            end else begin
              alu_cin = 1'b0;
            end
          end
          2'b10: begin
            case (sub_s)
              3'b000: reg_write = 1'b1;
              3'b001: mem_write = 1'b1;
              3'b010: begin
                reg_write   = 1'b1;
                flag_c_nx_s = shift_c;
                flag_z_nx_s = shift_z;
              end
              3'b100: begin
                pc_en      = 1'b0;
                state_nx_s = ST_HALT;
              end
              default: pc_sel = 2'b00;
            endcase
          end
          2'b11: begin
            case (sub_s)
              3'b000: pc_sel = flag_z_r  ? 2'b01 : 2'b00;
              3'b001: pc_sel = !flag_z_r ? 2'b01 : 2'b00;
              3'b010: pc_sel = flag_c_r  ? 2'b01 : 2'b00;
              3'b011: pc_sel = !flag_c_r ? 2'b01 : 2'b00;
              3'b100: pc_sel = 2'b10;
              3'b101: begin
                // A full stack refuses the call instead of wrapping.
                if (level_r == LVL_FULL) begin
                  pc_en      = 1'b0;
                  state_nx_s = ST_FAULT;
                end else begin
                  push       = 1'b1;
                  pc_sel     = 2'b10;
                  level_nx_s = level_r + LVL_ONE;
                end
              end
              3'b110: begin
                if (level_r == LVL_ZERO) begin
                  pc_en      = 1'b0;
                  state_nx_s = ST_FAULT;
                end else begin
                  pop        = 1'b1;
                  pc_sel     = 2'b11;
                  level_nx_s = level_r - LVL_ONE;
                end
              end
              default: pc_sel = 2'b00;
            endcase
          end
          default: pc_en = 1'b1;
        endcase
      end
      ST_HALT:  state_nx_s = ST_HALT;
      ST_FAULT: state_nx_s = ST_FAULT;
      default:  state_nx_s = ST_FAULT;
    endcase
  end

  // State, flag and stack-level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_INIT;
      flag_c_r <= 1'b0;
      flag_z_r <= 1'b0;
      level_r  <= LVL_ZERO;
    end else begin
      state_r  <= state_nx_s;
      flag_c_r <= flag_c_nx_s;
      flag_z_r <= flag_z_nx_s;
      level_r  <= level_nx_s;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: an instruction-level model is
// compared against every cycle's outputs, plus hand-computed spot checks.
module tb_control_sequencer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [18:0] instruction = 19'd0;
  logic        alu_co = 1'b0;
  logic        alu_z = 1'b0;
  logic        shift_c = 1'b0;
  logic        shift_z = 1'b0;
  logic        reg_write, mem_write, push, pop, alu_cin, pc_en;
  logic        flag_c, flag_z, halted, fault;
  logic [2:0]  alu_op;
  logic [1:0]  pc_sel;
  logic [3:0]  stack_level;

  int errors = 0;
  int checks = 0;

  // Model state: mode 0=INIT 1=RUN 2=HALT 3=FAULT
  int   m_mode;
  logic m_c;
  logic m_z;
  int   m_lvl;

  control_sequencer #(.STACK_DEPTH(DEPTH), .LVL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction),
    .alu_co(alu_co), .alu_z(alu_z), .shift_c(shift_c), .shift_z(shift_z),
    .reg_write(reg_write), .mem_write(mem_write), .push(push), .pop(pop),
    .alu_op(alu_op), .alu_cin(alu_cin), .pc_sel(pc_sel), .pc_en(pc_en),
    .flag_c(flag_c), .flag_z(flag_z), .stack_level(stack_level),
    .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] ins(input logic [1:0] c, input logic [2:0] s);
    return {c, s, 14'h2A5C};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_c    = 1'b0;
    m_z    = 1'b0;
    m_lvl  = 0;
  endtask

  // Expected output word from the instruction-level meaning of the current opcode.
  function automatic logic [18:0] model_out();
    int   op, grp, fn;
    logic rw, mw, ps, pp, cin, pe, taken;
    logic [2:0] aop;
    logic [1:0] ps_sel;
    op = int'(instruction[18:14]);
    grp = op / 8;
    fn = op % 8;
    rw = 0; mw = 0; ps = 0; pp = 0; cin = 0; pe = 0; aop = 3'd0; ps_sel = 2'd0;
    if (m_mode == 1) begin
      pe = 1;
      if (grp <= 1) begin
        rw = 1;
        aop = 3'(fn);
        cin = ((fn == 1) || (fn == 3)) ? m_c : 1'b0;
      end else if (grp == 2) begin
        if (fn == 0 || fn == 2) rw = 1;
        if (fn == 1) mw = 1;
        if (fn == 4) pe = 0;
      end else begin
        if (fn <= 3) begin
          taken = (fn == 0) ? m_z : (fn == 1) ? !m_z : (fn == 2) ? m_c : !m_c;
          ps_sel = taken ? 2'd1 : 2'd0;
        end
        if (fn == 4) ps_sel = 2'd2;
        if (fn == 5) begin
          if (m_lvl < DEPTH) begin ps = 1; ps_sel = 2'd2; end
          else pe = 0;
        end
        if (fn == 6) begin
          if (m_lvl > 0) begin pp = 1; ps_sel = 2'd3; end
          else pe = 0;
        end
      end
    end
    return {rw, mw, ps, pp, aop, cin, ps_sel, pe, m_c, m_z, 4'(m_lvl),
            (m_mode == 2), (m_mode == 3)};
  endfunction

  task automatic model_edge();
    int op, grp, fn;
    op = int'(instruction[18:14]);
    grp = op / 8;
    fn = op % 8;
    if (!rst_n) model_reset();
    else if (m_mode == 0) m_mode = 1;
    else if (m_mode == 1) begin
      if (grp <= 1) begin m_c = alu_co; m_z = alu_z; end
      else if (op == 16 + 2) begin m_c = shift_c; m_z = shift_z; end
      else if (op == 16 + 4) m_mode = 2;
      else if (op == 24 + 5) begin
        if (m_lvl < DEPTH) m_lvl++; else m_mode = 3;
      end else if (op == 24 + 6) begin
        if (m_lvl > 0) m_lvl--; else m_mode = 3;
      end
    end
  endtask

  // Drive inputs, then compare the whole output word at the falling edge.
  task automatic apply(input logic [18:0] i, input logic co = 1'b0, input logic z = 1'b0,
                       input logic sc = 1'b0, input logic sz = 1'b0);
    logic [18:0] e, g;
    instruction = i; alu_co = co; alu_z = z; shift_c = sc; shift_z = sz;
    @(negedge clk);
    e = model_out();
    g = {reg_write, mem_write, push, pop, alu_op, alu_cin, pc_sel, pc_en,
         flag_c, flag_z, stack_level, halted, fault};
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL cycle t=%0t inst=%h got %b expected %b", $time, i, g, e);
    end
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    model_reset();
    repeat (2) begin
      apply(ins(2'b00, 3'b010));
      check("reset_outputs", {reg_write, mem_write, push, pop, alu_op, pc_sel, pc_en, halted, fault}, 0);
      tick();
    end
    rst_n = 1'b1;

    apply(ins(2'b00, 3'b010));
    check("init_pc_en", pc_en, 0);
    check("init_reg_write", reg_write, 0);
    tick();
    apply(ins(2'b00, 3'b010));
    check("r_reg_write", reg_write, 1);
    check("r_alu_op", alu_op, 3'b010);
    check("r_pc_en", pc_en, 1);
    tick();

    apply(ins(2'b00, 3'b000), 1'b1, 1'b0); tick();
    check("add_flag_c", flag_c, 1);
    apply(ins(2'b11, 3'b010));
    check("bc_taken", pc_sel, 2'b01);
    tick();
    apply(ins(2'b01, 3'b010), 1'b0, 1'b1); tick();
    apply(ins(2'b11, 3'b011));
    check("bnc_taken", pc_sel, 2'b01);
    check("sub_flag_z", flag_z, 1);
    tick();
    apply(ins(2'b11, 3'b000)); tick();
    apply(ins(2'b11, 3'b001)); tick();
    apply(ins(2'b00, 3'b000), 1'b1, 1'b0); tick();
    apply(ins(2'b00, 3'b001));
    check("carry_cin", alu_cin, 1);
    tick();
    apply(ins(2'b01, 3'b011));
    check("cin_flag_clear", alu_cin, 0);
    tick();

    apply(ins(2'b10, 3'b010), 1'b0, 1'b0, 1'b1, 1'b1); tick();
    check("shift_flags", {flag_c, flag_z}, 2'b11);
    apply(ins(2'b01, 3'b101));
    check("op5_no_cin", alu_cin, 0);
    tick();
    apply(ins(2'b10, 3'b011)); tick();
    apply(ins(2'b10, 3'b111)); tick();
    apply(ins(2'b11, 3'b111)); tick();
    apply(ins(2'b11, 3'b100));
    check("jmp_sel", pc_sel, 2'b10);
    tick();

    apply(ins(2'b10, 3'b001));
    check("sm_write", mem_write, 1);
    tick();
    apply(ins(2'b10, 3'b000));
    check("lm_no_mem", mem_write, 0);
    check("lm_reg", reg_write, 1);
    tick();
    apply(ins(2'b11, 3'b101));
    check("jsb_push_sel", {push, pc_sel}, 3'b110);
    tick();
    check("jsb_level", stack_level, 1);
    apply(ins(2'b11, 3'b110));
    check("ret_pop_sel", {pop, pc_sel}, 3'b111);
    tick();
    check("ret_level", stack_level, 0);

    apply(ins(2'b00, 3'b000), 1'b1, 1'b1); tick();
    for (int k = 0; k < 8; k++) begin
      apply(ins(2'b11, 3'b101));
      tick();
    end
    check("full_level", stack_level, 8);
    apply(ins(2'b11, 3'b101));
    check("overflow_push_pcen", {push, pc_en}, 2'b00);
    tick();
    check("overflow_fault", fault, 1);
    apply(ins(2'b11, 3'b101));
    check("fault_sticky", {fault, stack_level, flag_c}, {1'b1, 4'd8, 1'b1});
    rst_n = 1'b0;
    model_reset();
    #2;
    check("async_clear", {fault, flag_c, flag_z, stack_level}, 0);
    tick();
    rst_n = 1'b1;

    apply(ins(2'b11, 3'b110)); tick();
    apply(ins(2'b11, 3'b110));
    check("underflow_pop_pcen", {pop, pc_en}, 2'b00);
    tick();
    check("underflow_fault", fault, 1);
    apply(ins(2'b10, 3'b000));
    check("fault_no_strobe", reg_write, 0);
    tick();

    rst_n = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;
    apply(ins(2'b10, 3'b100)); tick();
    apply(ins(2'b10, 3'b100));
    check("halt_pc_en", pc_en, 0);
    tick();
    check("halted_set", {halted, fault}, 2'b10);
    apply(ins(2'b10, 3'b001));
    check("halt_no_mem", mem_write, 0);
    tick();
    apply(ins(2'b11, 3'b100));
    check("halt_sticky", {halted, pc_en}, 2'b10);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
